// File: rtl/horner_pkg.sv
// rtl/horner_pkg.sv - shared FSM encoding and saturation helper for the Horner evaluator
package horner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int SAT_W = 64;

    // True when v lies outside the signed range of a wl-bit word.
    function automatic logic sat_hit(input logic signed [SAT_W-1:0] v, input int wl);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) || (v < lo);
    endfunction

endpackage

// File: rtl/horner_sat.sv
// rtl/horner_sat.sv - combinational signed clamp from WLin to WLout bits with a hit flag
module horner_sat
    import horner_pkg::*;
#(
    parameter int WLin  = 22,
    parameter int WLout = 16
) (
    input  logic signed [WLin-1:0]  din_i,
    output logic signed [WLout-1:0] dout_o,
    output logic                    sat_hit_o
);

    logic hit;

    always_comb begin
        hit = sat_hit(SAT_W'(din_i), WLout);
        if (hit) begin
            // Clamp toward the sign of the input: 100..0 for negative, 011..1 for positive.
            dout_o = {din_i[WLin-1], {(WLout-1){~din_i[WLin-1]}}};
        end else begin
            dout_o = din_i[WLout-1:0];
        end
        sat_hit_o = hit;
    end

endmodule

// File: rtl/horner_poly_eval.sv
// rtl/horner_poly_eval.sv - Horner-form polynomial evaluator, one shared multiplier and adder
module horner_poly_eval
    import horner_pkg::*;
#(
    parameter int WLx    = 6,
    parameter int WLc    = 4,
    parameter int ORDER  = 3,
    parameter int WLacc  = 16,
    parameter int FRAC   = 0,
    parameter int WLaddr = $clog2(ORDER + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    coef_we_i,
    input  logic [WLaddr-1:0]       coef_addr_i,
    input  logic signed [WLc-1:0]   coef_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [WLx-1:0]   x_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [WLacc-1:0] y_o,
    output logic                    ovf_o,
    output logic                    busy_o
);

    localparam int WLP = WLacc + WLx;
    localparam int WLS = WLacc + 1;

    state_e                  state_q;
    logic signed [WLc-1:0]   coef_q [0:ORDER];
    logic signed [WLx-1:0]   x_q;
    logic signed [WLacc-1:0] acc_q;
    logic signed [WLacc-1:0] prod_q;
    logic [WLaddr-1:0]       step_q;
    logic signed [WLacc-1:0] y_q;
    logic                    ovf_q;
    logic                    out_valid_q;
    logic                    in_ready_q;
    logic                    busy_q;

    logic signed [WLP-1:0]   prod_full;
    logic signed [WLS-1:0]   sum_full;
    logic signed [WLacc-1:0] prod_d;
    logic signed [WLacc-1:0] acc_d;
    logic                    mul_hit;
    logic                    add_hit;
    logic                    coef_addr_ok;

    // WLP bits hold any WLacc x WLx signed product exactly, so the shift sees the true value.
    assign prod_full    = (WLP'(acc_q) * WLP'(x_q)) >>> FRAC;
    assign sum_full     = WLS'(prod_q) + WLS'(coef_q[step_q]);
    assign coef_addr_ok = (32'(coef_addr_i) <= ORDER);

    horner_sat #(
        .WLin  (WLP),
        .WLout (WLacc)
    ) u_mul_sat (
        .din_i     (prod_full),
        .dout_o    (prod_d),
        .sat_hit_o (mul_hit)
    );

    horner_sat #(
        .WLin  (WLS),
        .WLout (WLacc)
    ) u_add_sat (
        .din_i     (sum_full),
        .dout_o    (acc_d),
        .sat_hit_o (add_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            coef_q      <= '{default: '0};
            x_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            step_q      <= '0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (coef_we_i && coef_addr_ok) begin
                        coef_q[coef_addr_i] <= coef_data_i;
                    end
                    // acc loads the pre-write c0 even if c0 is written on this same edge.
                    if (in_valid_i) begin
                        x_q        <= x_i;
                        acc_q      <= WLacc'(coef_q[0]);
                        step_q     <= WLaddr'(1);
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod_q  <= prod_d;
                    ovf_q   <= ovf_q | mul_hit;
                    state_q <= ST_ADD;
                end
                ST_ADD: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_q | add_hit;
                    if (step_q == WLaddr'(ORDER)) begin
                        y_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        step_q  <= step_q + WLaddr'(1);
                        state_q <= ST_MUL;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign y_o         = y_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_horner_poly_eval.sv
// tb/tb_horner_poly_eval.sv - randomized self-checking bench for horner_poly_eval
module tb_horner_poly_eval;

    localparam int WLx    = 6;
    localparam int WLc    = 4;
    localparam int ORDER  = 3;
    localparam int WLacc  = 16;
    localparam int FRAC   = 0;
    localparam int WLaddr = 2;
    localparam longint SAT_HI = (64'sd1 <<< (WLacc - 1)) - 1;
    localparam longint SAT_LO = -(64'sd1 <<< (WLacc - 1));

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    coef_we;
    logic [WLaddr-1:0]       coef_addr;
    logic signed [WLc-1:0]   coef_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WLx-1:0]   x;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WLacc-1:0] y;
    logic                    ovf;
    logic                    busy;

    int checks = 0;
    int errors = 0;
    int c_model [0:ORDER];

    always #5 clk = ~clk;

    horner_poly_eval #(
        .WLx    (WLx),
        .WLc    (WLc),
        .ORDER  (ORDER),
        .WLacc  (WLacc),
        .FRAC   (FRAC),
        .WLaddr (WLaddr)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    function automatic longint clamp(input longint v, inout bit hit);
        if (v > SAT_HI) begin hit = 1'b1; return SAT_HI; end
        if (v < SAT_LO) begin hit = 1'b1; return SAT_LO; end
        return v;
    endfunction

    // Reference: y = sum c[k]*x^(N-k) in Horner order, saturating after every product and sum.
    function automatic void model(input int xv, output longint ye, output bit oe);
        longint acc;
        oe  = 1'b0;
        acc = c_model[0];
        for (int k = 1; k <= ORDER; k++) begin
            acc = clamp((acc * xv) >>> FRAC, oe);
            acc = clamp(acc + c_model[k], oe);
        end
        ye = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int data);
        logic [31:0] a;
        logic [31:0] d;
        a = addr;
        d = data;
        coef_we   = 1'b1;
        coef_addr = a[WLaddr-1:0];
        coef_data = d[WLc-1:0];
        tick();
        coef_we = 1'b0;
        c_model[addr] = data;
    endtask

    task automatic write_all(input int c0, input int c1, input int c2, input int c3);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
    endtask

    // Accepts x, waits for out_valid and returns the edge count from the accepting edge.
    task automatic run_eval(input int xv, output longint yo, output bit oo, output int lat);
        logic [31:0] xb;
        xb = xv;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = xb[WLx-1:0];
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL eval_timeout: out_valid=%0b after %0d cycles required 1", out_valid, lat);
        end
        yo = longint'(y);
        oo = ovf;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic check_eval(input string name, input int xv, input longint y_req, input bit o_req);
        longint yo;
        bit     oo;
        int     lat;
        run_eval(xv, yo, oo, lat);
        checks++;
        if (yo !== y_req || oo !== o_req) begin
            errors++;
            $display("FAIL %s: y=%0d ovf=%0b required y=%0d ovf=%0b", name, yo, oo, y_req, o_req);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%0b y=%0d ovf=%0b ir=%0b busy=%0b required 0 0 0 1 0",
                     out_valid, y, ovf, in_ready, busy);
        end
        check_eval("reset_coefs_zero", 9, 0, 1'b0);
    endtask

    task automatic test_basic();
        longint ye;
        bit     oe;
        longint yo;
        bit     oo;
        int     lat;
        write_all(1, 2, 3, 4);
        run_eval(2, yo, oo, lat);
        checks++;
        if (yo !== 26 || oo !== 1'b0) begin
            errors++;
            $display("FAIL basic_x2: y=%0d ovf=%0b required y=26 ovf=0", yo, oo);
        end
        checks++;
        if (lat !== 2 * ORDER + 1) begin
            errors++;
            $display("FAIL latency: %0d cycles required %0d", lat, 2 * ORDER + 1);
        end
        check_eval("basic_xm1", -1, 2, 1'b0);
        model(-32, ye, oe);
        check_eval("basic_xmin", -32, ye, oe);
    endtask

    task automatic test_saturation();
        longint ye;
        bit     oe;
        write_all(7, 7, 7, 7);
        check_eval("sat_pos", 31, 32767, 1'b1);
        write_all(-8, 7, 7, 7);
        model(31, ye, oe);
        check_eval("sat_neg", 31, ye, oe);
        checks++;
        if (ye !== SAT_LO + 7 || oe !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_model: y=%0d ovf=%0b required y=%0d ovf=1", ye, oe, SAT_LO + 7);
        end
    endtask

    task automatic test_backpressure();
        logic signed [WLacc-1:0] y_hold;
        logic                    o_hold;
        int                      lat;
        longint                  ye;
        bit                      oe;
        write_all(1, 2, 3, 4);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 6'sd2;
        tick();
        x   = 6'sd3;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        y_hold = y;
        o_hold = ovf;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || y !== y_hold || ovf !== o_hold || in_ready !== 1'b0 || y_hold !== 16'sd26) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%0b y=%0d ovf=%0b ir=%0b required 1 26 %0b 0",
                         i, out_valid, y, ovf, in_ready, o_hold);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ov=%0b ir=%0b busy=%0b required 0 1 0", out_valid, in_ready, busy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: busy=%0b ir=%0b required 1 0", busy, in_ready);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        model(3, ye, oe);
        checks++;
        if (longint'(y) !== ye || ovf !== oe) begin
            errors++;
            $display("FAIL bp_second_result: y=%0d ovf=%0b required y=%0d ovf=%0b", y, ovf, ye, oe);
        end
        tick();
    endtask

    task automatic test_coef_lock();
        longint ye;
        bit     oe;
        int     lat;
        write_all(1, 2, 3, 4);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 6'sd2;
        tick();
        in_valid  = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'd3;
        coef_data = 4'sd5;
        tick();
        coef_we = 1'b0;
        lat = 2;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        checks++;
        if (y !== 16'sd26) begin
            errors++;
            $display("FAIL lock_busy_write: y=%0d required 26", y);
        end
        out_ready = 1'b1;
        tick();
        check_eval("lock_repeat", 2, 26, 1'b0);
        write_coef(3, 5);
        check_eval("lock_idle_write", 2, 27, 1'b0);
        // c0 written on the accepting edge: this evaluation still sees c0=1.
        out_ready = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = -4'sd3;
        in_valid  = 1'b1;
        x         = 6'sd2;
        tick();
        coef_we  = 1'b0;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        checks++;
        if (y !== 16'sd27) begin
            errors++;
            $display("FAIL same_edge_c0: y=%0d required 27", y);
        end
        out_ready = 1'b1;
        tick();
        c_model[0] = -3;
        model(2, ye, oe);
        check_eval("same_edge_after", 2, ye, oe);
    endtask

    task automatic test_random();
        longint ye;
        bit     oe;
        int     xv;
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k <= ORDER; k++) begin
                write_coef(k, int'($urandom_range(15)) - 8);
            end
            xv = int'($urandom_range(63)) - 32;
            model(xv, ye, oe);
            check_eval($sformatf("random[%0d]", n), xv, ye, oe);
        end
    endtask

    task automatic test_reset_mid();
        write_all(1, 2, 3, 4);
        check_eval("pre_reset", 2, 26, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 6'sd4;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ov=%0b y=%0d ir=%0b busy=%0b ovf=%0b required 0 0 1 0 0",
                     out_valid, y, in_ready, busy, ovf);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k <= ORDER; k++) c_model[k] = 0;
        tick();
        check_eval("post_reset_coefs", 5, 0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b1;
        for (int k = 0; k <= ORDER; k++) c_model[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_coef_lock();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
